// File: rtl/level_sequencer.sv
// level_sequencer: game-round controller for the password puzzle.
// Generates a per-level password from a 16-bit LFSR, runs a BCD countdown,
// and scores guesses taken on rising edges of `enter`. The round ends in WIN
// after the last level, or in FAIL when the countdown expires.
// Optional build macro: ATTEMPT_LIMIT_EN adds the attempts_left output and
// ends the round after MAX_ATTEMPTS wrong guesses on one level.
module level_sequencer #(
    parameter int          PW_W         = 10,
    parameter int          NUM_LEVELS   = 9,
    parameter int          TICK_DIV     = 100_000_000,
    parameter int          START_SECS   = 30,
    parameter int          SEC_STEP     = 3,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1,
    parameter int          MAX_ATTEMPTS = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            enter,
    input  logic [PW_W-1:0] guess,
    output logic [PW_W-1:0] password,
    output logic [PW_W-1:0] match_mask,
    output logic            mask_valid,
    output logic [3:0]      level,
    output logic [3:0]      secs_tens,
    output logic [3:0]      secs_ones,
    output logic            busy,
    output logic            win,
`ifdef ATTEMPT_LIMIT_EN
    output logic [3:0]      attempts_left,
`endif
    output logic            fail
);

    localparam int TICK_W = $clog2(TICK_DIV);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [3:0] LAST_LEVEL = 4'(NUM_LEVELS);

    // Out-of-range configurations are rejected at elaboration.
    if (TICK_DIV < 2 || LFSR_SEED == '0 || NUM_LEVELS < 1 || NUM_LEVELS > 9 ||
        START_SECS < 5 || START_SECS > 99 || PW_W < 1 || PW_W > 16 ||
        MAX_ATTEMPTS < 1 || MAX_ATTEMPTS > 15) begin : gBadParams
        $error("level_sequencer: parameter out of range");
    end

    typedef enum logic [2:0] {
        IDLE,
        GEN,
        PLAY,
        CHECK,
        ADVANCE,
        WIN,
        FAIL
    } seqState_t;

    seqState_t         state;
    seqState_t         nextState;

    logic [15:0]       lfsr;
    logic              lfsrFeedback;
    logic [TICK_W-1:0] tickCount;
    logic              secTick;
    logic              secsZero;
    logic              expired;
    logic              enterQ;
    logic              enterRise;
    logic [PW_W-1:0]   guessReg;
    logic              guessHit;
    logic [PW_W-1:0]   lfsrPw;
    logic [3:0]        startTens;
    logic [3:0]        startOnes;
    int                levelOffset;
    int                startVal;

    assign lfsrFeedback = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
    assign lfsrPw       = lfsr[PW_W-1:0];
    assign enterRise    = enter & ~enterQ;
    assign secTick      = (state == PLAY) && (tickCount == TICK_LAST);
    assign secsZero     = (secs_tens == 4'd0) && (secs_ones == 4'd0);
    assign expired      = secTick && secsZero;
    assign guessHit     = (guessReg == password);

    // Level start time: START_SECS less SEC_STEP per completed level, floored at 5, as BCD.
    always_comb begin
        levelOffset = (int'(level) - 1) * SEC_STEP;
        startVal    = START_SECS - levelOffset;
        if (startVal < 5) begin
            startVal = 5;
        end
        startTens = 4'(startVal / 10);
        startOnes = 4'(startVal % 10);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic; countdown expiry takes priority over a same-cycle guess.
    always_comb begin
        nextState = state;
        unique case (state)
            IDLE:    if (start) nextState = GEN;
            GEN:     nextState = PLAY;
            PLAY: begin
                if (expired) begin
                    nextState = FAIL;
                end else if (enterRise) begin
                    nextState = CHECK;
                end
            end
            CHECK: begin
                if (guessHit) begin
                    nextState = ADVANCE;
                end else begin
`ifdef ATTEMPT_LIMIT_EN
                    nextState = (attempts_left == 4'd1) ? FAIL : PLAY;
`else
                    nextState = PLAY;
`endif
                end
            end
            ADVANCE: nextState = (level == LAST_LEVEL) ? WIN : GEN;
            WIN:     if (start) nextState = GEN;
            FAIL:    if (start) nextState = GEN;
            default: nextState = IDLE;
        endcase
    end

    // Status outputs decoded from the current state.
    always_comb begin
        busy = 1'b0;
        win  = 1'b0;
        fail = 1'b0;
        unique case (state)
            GEN, PLAY, CHECK, ADVANCE: busy = 1'b1;
            WIN:                       win  = 1'b1;
            FAIL:                      fail = 1'b1;
            default:                   ;
        endcase
    end

    // Free-running LFSR, stepped every cycle outside reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsrFeedback, lfsr[15:1]};
        end
    end

    // Enter edge register, updated in every state so held buttons never retrigger.
    always_ff @(posedge clk) begin
        if (!reset) begin
            enterQ <= 1'b0;
        end else begin
            enterQ <= enter;
        end
    end

    // Seconds prescaler: cleared in GEN, runs in PLAY, holds elsewhere.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tickCount <= '0;
        end else if (state == GEN) begin
            tickCount <= '0;
        end else if (state == PLAY) begin
            tickCount <= secTick ? '0 : tickCount + 1'b1;
        end
    end

    // BCD countdown: loaded in GEN, decremented once per second in PLAY.
    always_ff @(posedge clk) begin
        if (!reset) begin
            secs_tens <= 4'd0;
            secs_ones <= 4'd0;
        end else if (state == GEN) begin
            secs_tens <= startTens;
            secs_ones <= startOnes;
        end else if (secTick && !secsZero) begin
            if (secs_ones == 4'd0) begin
                secs_ones <= 4'd9;
                secs_tens <= secs_tens - 4'd1;
            end else begin
                secs_ones <= secs_ones - 4'd1;
            end
        end
    end

    // Level counter; levels stay within 1..9 so binary and BCD coincide.
    always_ff @(posedge clk) begin
        if (!reset) begin
            level <= 4'd1;
        end else if ((state == IDLE || state == WIN || state == FAIL) && start) begin
            level <= 4'd1;
        end else if (state == ADVANCE && level != LAST_LEVEL) begin
            level <= level + 4'd1;
        end
    end

    // Password load in GEN; an all-zero LFSR slice is replaced by 1.
    always_ff @(posedge clk) begin
        if (!reset) begin
            password <= '0;
        end else if (state == GEN) begin
            password <= (lfsrPw == '0) ? PW_W'(1) : lfsrPw;
        end
    end

    // Guess capture on an accepted enter edge; discarded when the timer expires that cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            guessReg <= '0;
        end else if (state == PLAY && enterRise && !expired) begin
            guessReg <= guess;
        end
    end

    // Match mask and its valid pulse, both registered out of CHECK.
    always_ff @(posedge clk) begin
        if (!reset) begin
            match_mask <= '0;
            mask_valid <= 1'b0;
        end else begin
            mask_valid <= (state == CHECK);
            if (state == GEN) begin
                match_mask <= '0;
            end else if (state == CHECK) begin
                match_mask <= ~(guessReg ^ password);
            end
        end
    end

`ifdef ATTEMPT_LIMIT_EN
    // Remaining wrong guesses for this level: reloaded in GEN, spent on each mismatch.
    always_ff @(posedge clk) begin
        if (!reset) begin
            attempts_left <= 4'd0;
        end else if (state == GEN) begin
            attempts_left <= 4'(MAX_ATTEMPTS);
        end else if (state == CHECK && !guessHit && attempts_left != 4'd0) begin
            attempts_left <= attempts_left - 4'd1;
        end
    end
`endif

endmodule

// File: tb/tb_level_sequencer.sv
// tb_level_sequencer: directed test of level_sequencer with a fast prescaler
// (TICK_DIV=4) and three levels. The ATTEMPT_LIMIT_EN section runs only when
// the macro is defined for both bench and design.
module tb_level_sequencer;

    localparam int          PW_W       = 10;
    localparam logic [15:0] SEED       = 16'hACE1;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            start = 1'b0;
    logic            enter = 1'b0;
    logic [PW_W-1:0] guess = '0;
    logic [PW_W-1:0] password;
    logic [PW_W-1:0] match_mask;
    logic            mask_valid;
    logic [3:0]      level;
    logic [3:0]      secs_tens;
    logic [3:0]      secs_ones;
    logic            busy;
    logic            win;
    logic            fail;
`ifdef ATTEMPT_LIMIT_EN
    logic [3:0]      attempts_left;
`endif

    int total = 0;
    int bad   = 0;
    logic [15:0]     lfsrM;
    logic [PW_W-1:0] expPw;
    int              pulseCount;

    level_sequencer #(
        .PW_W        (PW_W),
        .NUM_LEVELS  (3),
        .TICK_DIV    (4),
        .START_SECS  (30),
        .SEC_STEP    (3),
        .LFSR_SEED   (SEED),
        .MAX_ATTEMPTS(3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .enter     (enter),
        .guess     (guess),
        .password  (password),
        .match_mask(match_mask),
        .mask_valid(mask_valid),
        .level     (level),
        .secs_tens (secs_tens),
        .secs_ones (secs_ones),
        .busy      (busy),
        .win       (win),
`ifdef ATTEMPT_LIMIT_EN
        .attempts_left(attempts_left),
`endif
        .fail      (fail)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lfsrNext(input logic [15:0] v);
        logic fb;
        fb = v[0] ^ v[2] ^ v[3] ^ v[5];
        return {fb, v[15:1]};
    endfunction

    function automatic logic [PW_W-1:0] pwOf(input logic [15:0] v);
        logic [PW_W-1:0] p;
        p = v[PW_W-1:0];
        return (p == '0) ? PW_W'(1) : p;
    endfunction

    function automatic logic [7:0] bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    // Reference LFSR tracking the design's reset and stepping.
    always @(posedge clk) begin
        if (!reset) lfsrM <= SEED;
        else        lfsrM <= lfsrNext(lfsrM);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset low for two cycles, then release.
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        check("rst_pw",    32'(password), 0);
        check("rst_mask",  32'(match_mask), 0);
        check("rst_valid", 32'(mask_valid), 0);
        check("rst_level", 32'(level), 1);
        check("rst_secs",  32'({secs_tens, secs_ones}), 32'h00);
        check("rst_busy",  32'(busy), 0);
        check("rst_win",   32'(win), 0);
        check("rst_fail",  32'(fail), 0);
`ifdef ATTEMPT_LIMIT_EN
        check("rst_attempts", 32'(attempts_left), 0);
`endif
        step();
        step();
        check("idle_busy", 32'(busy), 0);

        // Start: one GEN cycle, then PLAY with password and 30 s loaded.
        start = 1'b1;
        step();
        start = 1'b0;
        expPw = pwOf(lfsrM);
        check("gen_busy", 32'(busy), 1);
        step();
        check("gen_pw",    32'(password), 32'(expPw));
        check("gen_pw_nz", 32'(password != '0), 1);
        check("gen_secs",  32'({secs_tens, secs_ones}), 32'h30);
        check("gen_level", 32'(level), 1);
        check("play_busy", 32'(busy), 1);
`ifdef ATTEMPT_LIMIT_EN
        check("gen_attempts", 32'(attempts_left), 3);
`endif

        // Countdown with no guesses, one second every 4 cycles.
        repeat (3) step();
        check("sec_hold", 32'({secs_tens, secs_ones}), 32'h30);
        step();
        check("sec_29", 32'({secs_tens, secs_ones}), 32'h29);
        for (int s = 28; s >= 0; s--) begin
            repeat (4) step();
            check("countdown", 32'({secs_tens, secs_ones}), 32'(bcd(s)));
        end
        repeat (3) step();
        check("zero_nofail", 32'(fail), 0);
        step();
        check("timeout_fail", 32'(fail), 1);
        check("timeout_busy", 32'(busy), 0);
        check("timeout_win",  32'(win), 0);
        repeat (3) step();
        check("fail_hold",      32'(fail), 1);
        check("fail_secs_hold", 32'({secs_tens, secs_ones}), 32'h00);

        // Restart from FAIL.
        start = 1'b1;
        step();
        start = 1'b0;
        expPw = pwOf(lfsrM);
        check("restart_fail_clr", 32'(fail), 0);
        check("restart_busy",     32'(busy), 1);
        check("restart_level",    32'(level), 1);
        step();
        check("restart_pw",   32'(password), 32'(expPw));
        check("restart_secs", 32'({secs_tens, secs_ones}), 32'h30);

        // Wrong guess (two low bits flipped), enter then held for 20 cycles.
        guess = expPw ^ 10'h003;
        enter = 1'b1;
        step();
        check("lat_n1_valid", 32'(mask_valid), 0);
        step();
        check("wrong_valid", 32'(mask_valid), 1);
        check("wrong_mask",  32'(match_mask), 32'h3FC);
        check("wrong_level", 32'(level), 1);
        check("wrong_busy",  32'(busy), 1);
        pulseCount = 0;
        repeat (20) begin
            step();
            if (mask_valid) pulseCount++;
        end
        check("hold_one_guess", 32'(pulseCount), 0);
        check("hold_mask", 32'(match_mask), 32'h3FC);
        enter = 1'b0;
        step();

        // Correct guesses through all three levels.
        for (int lvl = 1; lvl <= 3; lvl++) begin
            guess = expPw;
            enter = 1'b1;
            step();
            enter = 1'b0;
            step();
            check("hit_valid", 32'(mask_valid), 1);
            check("hit_mask",  32'(match_mask), 32'h3FF);
            step();
            if (lvl < 3) begin
                expPw = pwOf(lfsrM);
                check("adv_level", 32'(level), 32'(lvl + 1));
                check("adv_busy",  32'(busy), 1);
                step();
                check("adv_pw",   32'(password), 32'(expPw));
                check("adv_secs", 32'({secs_tens, secs_ones}), 32'(bcd(30 - 3 * lvl)));
            end else begin
                check("win_flag",  32'(win), 1);
                check("win_busy",  32'(busy), 0);
                check("win_level", 32'(level), 3);
            end
        end
        repeat (3) step();
        check("win_hold",      32'(win), 1);
        check("win_mask_hold", 32'(match_mask), 32'h3FF);

        // Enter edge in the same cycle as expiry at 00: fail wins, no mask.
        start = 1'b1;
        step();
        start = 1'b0;
        check("win_clr", 32'(win), 0);
        step();
        repeat (123) step();
        check("tie_secs",   32'({secs_tens, secs_ones}), 32'h00);
        check("tie_nofail", 32'(fail), 0);
        guess = 10'h155;
        enter = 1'b1;
        step();
        check("tie_fail",  32'(fail), 1);
        check("tie_valid", 32'(mask_valid), 0);
        enter = 1'b0;
        step();
        check("tie_valid_after", 32'(mask_valid), 0);
        check("tie_mask",        32'(match_mask), 0);

        // Reset during PLAY at level 2 with a non-zero mask.
        start = 1'b1;
        step();
        start = 1'b0;
        expPw = pwOf(lfsrM);
        step();
        guess = expPw;
        enter = 1'b1;
        step();
        enter = 1'b0;
        step();
        step();
        expPw = pwOf(lfsrM);
        step();
        check("pre_rst_level", 32'(level), 2);
        guess = expPw ^ 10'h003;
        enter = 1'b1;
        step();
        enter = 1'b0;
        step();
        check("pre_rst_mask", 32'(match_mask), 32'h3FC);
        reset = 1'b0;
        step();
        check("midrst_busy",  32'(busy), 0);
        check("midrst_level", 32'(level), 1);
        check("midrst_secs",  32'({secs_tens, secs_ones}), 32'h00);
        check("midrst_pw",    32'(password), 0);
        check("midrst_mask",  32'(match_mask), 0);
        check("midrst_valid", 32'(mask_valid), 0);
        check("midrst_fail",  32'(fail), 0);
        reset = 1'b1;
        step();
        check("midrst_idle", 32'(busy), 0);

`ifdef ATTEMPT_LIMIT_EN
        // Three wrong guesses exhaust the level.
        start = 1'b1;
        step();
        start = 1'b0;
        expPw = pwOf(lfsrM);
        step();
        check("att_load", 32'(attempts_left), 3);
        for (int k = 2; k >= 0; k--) begin
            guess = expPw ^ 10'h001;
            enter = 1'b1;
            step();
            enter = 1'b0;
            step();
            check("att_count", 32'(attempts_left), 32'(k));
            check("att_fail",  32'(fail), (k == 0) ? 1 : 0);
        end
        // Wrong then right: next level with attempts reloaded.
        start = 1'b1;
        step();
        start = 1'b0;
        expPw = pwOf(lfsrM);
        step();
        guess = expPw ^ 10'h001;
        enter = 1'b1;
        step();
        enter = 1'b0;
        step();
        check("att_second_try", 32'(attempts_left), 2);
        guess = expPw;
        enter = 1'b1;
        step();
        enter = 1'b0;
        step();
        step();
        step();
        check("att_next_level", 32'(level), 2);
        check("att_reload",     32'(attempts_left), 3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/level_sequencer.md
Name: level_sequencer

Overview:
- Game-round controller for the password puzzle.
- Sequences the password register, countdown timer and guess checking across levels.
- Generates a pseudo-random password per level, loads a per-level BCD countdown, and accepts and scores guesses on `enter` edges.
- Declares win after the last level or fail on timeout. Sits between the switch/button inputs and the seven-segment/LED display path.

Parameters:
- PW_W, 10, password and guess width in bits.
- NUM_LEVELS, 9, number of levels; level counter is 1..NUM_LEVELS, max 9.
- TICK_DIV, 100_000_000, clk cycles per countdown second; must be >= 2.
- START_SECS, 30, countdown start value for level 1; range 5..99.
- SEC_STEP, 3, seconds removed per level; start time is floored at 5.
- LFSR_SEED, 16'hACE1, reset value of the internal LFSR; must be non-zero.
- MAX_ATTEMPTS, 3, wrong guesses allowed per level; used only with ATTEMPT_LIMIT_EN.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- start  in  1  single-cycle pulse; begins or restarts a game.
- enter  in  1  guess button level, already synchronized; block edge-detects it.
- guess  in  PW_W  switch value sampled on an `enter` rising edge.
- password  out  PW_W  current level password.
- match_mask  out  PW_W  bitwise XNOR of the last guess and the password, for the LEDs.
- mask_valid  out  1  one-cycle pulse when match_mask updates.
- level  out  4  current level, BCD.
- secs_tens  out  4  countdown tens digit, BCD.
- secs_ones  out  4  countdown ones digit, BCD.
- busy  out  1  high in GEN, PLAY, CHECK and ADVANCE.
- win  out  1  sticky win flag.
- fail  out  1  sticky fail flag.

Behaviour:
- Reset (reset==0 at a clk edge) produces:
  - state IDLE, level=1, secs=00, password=0, match_mask=0.
  - mask_valid=0, busy=0, win=0, fail=0.
  - LFSR=LFSR_SEED, tick counter=0, enter edge register=0.
  - Reset mid-game aborts immediately to this state.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every cycle in every state except reset.
- States:
  - IDLE: start -> GEN.
  - GEN, 1 cycle:
    - password <= LFSR[PW_W-1:0]; if that value is 0, load 1 instead.
    - secs <= BCD(max(5, START_SECS - (level-1)*SEC_STEP)).
    - tick <= 0; match_mask <= 0. Next state PLAY.
  - PLAY:
    - tick increments each cycle. At TICK_DIV-1 it wraps to 0 and a "second" fires.
    - On a second: if secs==00 -> FAIL; else decrement BCD (ones 0 -> 9 with a tens borrow).
    - An enter rising edge latches guess -> CHECK.
    - If a second with secs==00 and an enter edge occur in the same cycle, FAIL wins and the guess is discarded.
  - CHECK, 1 cycle:
    - match_mask <= ~(guess ^ password); mask_valid=1; tick holds.
    - All bits match -> ADVANCE; otherwise -> PLAY.
  - ADVANCE, 1 cycle:
    - level==NUM_LEVELS -> WIN.
    - Otherwise level++ (BCD) -> GEN.
  - WIN: win=1. FAIL: fail=1.
    - Both hold all outputs until start, which clears win/fail, sets level=1 and goes to GEN.
- start is ignored in GEN, PLAY, CHECK and ADVANCE.
- enter held high produces exactly one guess; enter edges outside PLAY are ignored but still update the edge register.
- Guess-to-mask latency: enter edge seen in cycle N -> mask_valid in cycle N+2.

Optional Feature:
- Macro: ATTEMPT_LIMIT_EN.
- Defined:
  - Adds output `attempts_left`, 4 bits, loaded with MAX_ATTEMPTS in GEN.
  - Each CHECK with a mismatch decrements it. A mismatch when it is 1 -> FAIL instead of PLAY.
  - Reset value 0.
- Undefined:
  - No port, unlimited guesses. Behaviour is otherwise identical.

Test Plan:
- Reset low 2 cycles, then release -> all outputs at reset values, state IDLE; start -> password equals LFSR-derived value (non-zero), secs=3/0, level=1, busy=1.
- TICK_DIV=4; play without guessing -> secs decrements every 4 cycles 30, 29, …, 00; next second -> fail=1, busy=0; start -> level=1, secs=30.
- Correct guess on every level with NUM_LEVELS=3, SEC_STEP=3 -> level 1, 2, 3 with start times 30, 27, 24; after the level-3 CHECK, ADVANCE then win=1.
- Guess = password ^ 10'h003 -> mask_valid pulse 2 cycles after the edge, match_mask=10'h3FC, level unchanged, state PLAY; holding enter 20 cycles -> exactly one mask_valid.
- Enter edge in the same cycle as the final expiry at secs=00 -> fail=1, no mask_valid; reset low during PLAY -> IDLE with level=1, secs=00 next cycle.
- With ATTEMPT_LIMIT_EN and MAX_ATTEMPTS=3: three wrong guesses -> attempts_left 3, 2, 1, then fail=1; a correct guess on the second try -> next level with attempts_left reloaded to 3.
